// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle datapath and its control FSM.
// The FSM drives every select and strobe; the datapath returns opcode and the ALU zero flag.
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_write;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state_out;

    // Datapath side.
    modport master (
        output opcode, zero,
        input  pc_write, iord, mem_wr, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, state_out
    );

    // Control FSM side.
    modport slave (
        input  opcode, zero,
        output pc_write, iord, mem_wr, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, state_out
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for the multicycle datapath: sequences fetch/decode/execute for
// R-type, addi, lw, sw, beq and j, and counts memory wait cycles.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    mc_ctrl_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC_R     = 4'd4,
        S_WB_R       = 4'd5,
        S_ADDI_EX    = 4'd6,
        S_ADDI_WB    = 4'd7,
        S_MEM_ADDR   = 4'd8,
        S_MEM_RD     = 4'd9,
        S_MEM_WB     = 4'd10,
        S_MEM_WR     = 4'd11,
        S_BRANCH     = 4'd12,
        S_JUMP       = 4'd13,
        S_HALT       = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    // branch marks BRANCH so pc_write can follow the live zero flag there.
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic       branch;
    } ctrl_t;

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    ctrl_t      ctrl_q;

    function automatic ctrl_t decode(input state_e s, input logic [3:0] cnt);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_FETCH_WAIT: c.ir_write = (cnt == 4'd0);
            S_DECODE:     c.alu_src_b = 2'b11;
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_ADDI_EX, S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDI_WB: c.reg_write = 1'b1;
            S_MEM_RD:  c.iord = 1'b1;
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                c.iord   = 1'b1;
                c.mem_wr = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            S_HALT:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // NOTE: every variable written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                state_d    = S_FETCH_WAIT;
                wait_cnt_d = WAIT_LOAD;
            end
            S_FETCH_WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = S_DECODE;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_EXEC_R:  state_d = S_WB_R;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LW) begin
                    state_d    = S_MEM_RD;
                    wait_cnt_d = WAIT_LOAD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM_RD: begin
                if (wait_cnt_q == 4'd0) state_d = S_MEM_WB;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            S_WB_R, S_ADDI_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // NOTE: outputs are decoded from the next state/count, so the registered copy always
    // matches state_q in the following cycle without a combinational decode on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            wait_cnt_q <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ctrl_q     <= decode(state_d, wait_cnt_d);
        end
    end

    assign bus.pc_write   = ctrl_q.pc_write | (ctrl_q.branch & bus.zero);
    assign bus.iord       = ctrl_q.iord;
    assign bus.mem_wr     = ctrl_q.mem_wr;
    assign bus.ir_write   = ctrl_q.ir_write;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.pc_src     = ctrl_q.pc_src;
    assign bus.illegal    = ctrl_q.illegal;
    assign bus.state_out  = state_q;

endmodule
